button_debouncer: RTL and testbench



---
 rtl/debounce_pkg.sv | 18 +
 rtl/sync_2ff.sv | 25 ++
 rtl/button_debouncer.sv | 122 ++++++++++++
 tb/tb_button_debouncer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the pushbutton debounce logic.
// Other board-input conditioning blocks can reuse these definitions.
package debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } debounce_state_t;

    // Stable-time budget in clock cycles for a given clock rate and hold time.
    function automatic int unsigned ms_to_cycles(input int unsigned clk_freq_hz,
                                                 input int unsigned ms);
        return (clk_freq_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchroniser for asynchronous board inputs.
// The reset value is a parameter so each input can reset to its idle level.
module sync_2ff #(
    parameter int              WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Turns a raw bouncing pushbutton into a clean pressed level plus one-cycle
// press/release strobes for the reaction-time FSM.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ     = 50_000_000,
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS),
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic button_raw,
    output logic button_pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
            $error("button_debouncer: DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    logic            pin_sync;
    logic            btn_s;
    debounce_state_t state;
    logic [CNT_W-1:0] counter;

    // The pin is synchronised before the polarity flip so both flops reset to
    // the released pin level; XOR with a constant commutes with the flops.
    sync_2ff #(
        .WIDTH      (1),
        .RESET_VALUE(ACTIVE_LOW)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (button_raw),
        .q    (pin_sync)
    );

    assign btn_s = pin_sync ^ ACTIVE_LOW;

    // Wait states must see DEBOUNCE_CYCLES consecutive agreeing samples; any
    // reversal falls back to the previous stable state without a strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= RELEASED;
            counter        <= '0;
            button_pressed <= 1'b0;
            press_pulse    <= 1'b0;
            release_pulse  <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                RELEASED: begin
                    button_pressed <= 1'b0;
                    if (btn_s) begin
                        state   <= PRESS_WAIT;
                        counter <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state          <= RELEASED;
                        counter        <= '0;
                        button_pressed <= 1'b0;
                    end else if (counter == CNT_LAST) begin
                        state          <= PRESSED;
                        counter        <= '0;
                        button_pressed <= 1'b1;
                        press_pulse    <= 1'b1;
                    end else begin
                        counter        <= counter + CNT_W'(1);
                        button_pressed <= 1'b0;
                    end
                end
                PRESSED: begin
                    button_pressed <= 1'b1;
                    if (!btn_s) begin
                        state   <= RELEASE_WAIT;
                        counter <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s) begin
                        state          <= PRESSED;
                        counter        <= '0;
                        button_pressed <= 1'b1;
                    end else if (counter == CNT_LAST) begin
                        state          <= RELEASED;
                        counter        <= '0;
                        button_pressed <= 1'b0;
                        release_pulse  <= 1'b1;
                    end else begin
                        counter        <= counter + CNT_W'(1);
                        button_pressed <= 1'b1;
                    end
                end
                default: begin
                    state          <= RELEASED;
                    counter        <= '0;
                    button_pressed <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_pulses_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(press_pulse && release_pulse));
    a_press_single: assert property (@(posedge clk) disable iff (reset)
        !(press_pulse && $past(press_pulse)));
    a_release_single: assert property (@(posedge clk) disable iff (reset)
        !(release_pulse && $past(release_pulse)));
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: main instance (4 cycles, active-low),
// a 1-cycle instance sharing its pin, and an active-high polarity instance.
module tb_button_debouncer;

    logic clk = 1'b0;
    logic reset;
    logic button_raw;
    logic reset_pol;
    logic raw_pol;

    logic bp, pp, rp;
    logic one_bp, one_pp, one_rp;
    logic pol_bp, pol_pp, pol_rp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_debouncer #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .button_raw(button_raw),
        .button_pressed(bp), .press_pulse(pp), .release_pulse(rp)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(1), .ACTIVE_LOW(1'b1)) dut_one (
        .clk(clk), .reset(reset), .button_raw(button_raw),
        .button_pressed(one_bp), .press_pulse(one_pp), .release_pulse(one_rp)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0)) dut_pol (
        .clk(clk), .reset(reset_pol), .button_raw(raw_pol),
        .button_pressed(pol_bp), .press_pulse(pol_pp), .release_pulse(pol_rp)
    );

    // Advance one clock and settle just past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        reset_pol  = 1'b1;
        button_raw = 1'b1;
        raw_pol    = 1'b0;
        #2;
        checks++;
        if ({bp, pp, rp} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_async got %b expected 000", {bp, pp, rp});
        end
        checks++;
        if ({pol_bp, pol_pp, pol_rp} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_async_pol got %b expected 000", {pol_bp, pol_pp, pol_rp});
        end
        repeat (3) step();
        reset     = 1'b0;
        reset_pol = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if ({bp, pp, rp, one_bp, pol_bp} !== 5'b00000) begin
                errors++;
                $display("[TB] FAIL reset_idle cycle %0d got %b expected 00000", k,
                         {bp, pp, rp, one_bp, pol_bp});
            end
        end
    endtask

    task automatic test_clean_press();
        logic [2:0] exp;
        button_raw = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp = {k >= 7, k == 7, 1'b0};
            checks++;
            if ({bp, pp, rp} !== exp) begin
                errors++;
                $display("[TB] FAIL clean_press cycle %0d got %b expected %b", k, {bp, pp, rp}, exp);
            end
            if (k <= 10) begin
                exp = {k >= 4, k == 4, 1'b0};
                checks++;
                if ({one_bp, one_pp, one_rp} !== exp) begin
                    errors++;
                    $display("[TB] FAIL clean_press_one cycle %0d got %b expected %b", k,
                             {one_bp, one_pp, one_rp}, exp);
                end
            end
        end
    endtask

    task automatic test_release();
        logic [2:0] exp;
        button_raw = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp = {k < 7, 1'b0, k == 7};
            checks++;
            if ({bp, pp, rp} !== exp) begin
                errors++;
                $display("[TB] FAIL release cycle %0d got %b expected %b", k, {bp, pp, rp}, exp);
            end
            exp = {k < 4, 1'b0, k == 4};
            checks++;
            if ({one_bp, one_pp, one_rp} !== exp) begin
                errors++;
                $display("[TB] FAIL release_one cycle %0d got %b expected %b", k,
                         {one_bp, one_pp, one_rp}, exp);
            end
        end
    endtask

    task automatic test_short_glitch();
        button_raw = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if (k == 4) button_raw = 1'b1;
            step();
            checks++;
            if ({bp, pp, rp} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL short_glitch cycle %0d got %b expected 000", k, {bp, pp, rp});
            end
        end
    endtask

    task automatic test_bounce();
        logic [2:0] exp;
        for (int i = 0; i < 12; i++) begin
            button_raw = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            step();
            checks++;
            if ({bp, pp, rp} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL bounce_phase cycle %0d got %b expected 000", i, {bp, pp, rp});
            end
        end
        button_raw = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            exp = {k >= 7, k == 7, 1'b0};
            checks++;
            if ({bp, pp, rp} !== exp) begin
                errors++;
                $display("[TB] FAIL bounce_settle cycle %0d got %b expected %b", k, {bp, pp, rp}, exp);
            end
        end
    endtask

    task automatic test_reset_mid_press();
        logic [2:0] exp;
        repeat (3) step();
        checks++;
        if ({bp, pp, rp} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL mid_press_held got %b expected 100", {bp, pp, rp});
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bp, pp, rp} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL mid_press_async got %b expected 000", {bp, pp, rp});
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if ({bp, pp, rp} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL mid_press_hold cycle %0d got %b expected 000", k, {bp, pp, rp});
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp = {k >= 7, k == 7, 1'b0};
            checks++;
            if ({bp, pp, rp} !== exp) begin
                errors++;
                $display("[TB] FAIL mid_press_requal cycle %0d got %b expected %b", k, {bp, pp, rp}, exp);
            end
        end
    endtask

    task automatic test_polarity();
        logic [2:0] exp;
        raw_pol = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp = {k >= 7, k == 7, 1'b0};
            checks++;
            if ({pol_bp, pol_pp, pol_rp} !== exp) begin
                errors++;
                $display("[TB] FAIL polarity_press cycle %0d got %b expected %b", k,
                         {pol_bp, pol_pp, pol_rp}, exp);
            end
        end
        raw_pol = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp = {k < 7, 1'b0, k == 7};
            checks++;
            if ({pol_bp, pol_pp, pol_rp} !== exp) begin
                errors++;
                $display("[TB] FAIL polarity_release cycle %0d got %b expected %b", k,
                         {pol_bp, pol_pp, pol_rp}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_short_glitch();
        test_bounce();
        test_reset_mid_press();
        test_polarity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
